aes_ctr_keystream: RTL and testbench
====================================

# aes_ctr_keystream

Parametrised CTR-mode keystream engine placed between the system bus and the 12-cycle masked AES-128 encryption core. It loads an IV and a block count, issues successive counter blocks to the core one at a time, and buffers the two-share core results in an output FIFO with valid/ready backpressure. The generalisations are:

- **Mode:** single-block ECB becomes streaming CTR.
- **Counter width:** configurable.
- **Buffering:** configurable FIFO depth.

The key and its share 2 stay loaded in the core; this block never handles key material.

## Interface
Parameters:
- CTR_W, 32, width of the incrementing low field of the counter block (8..128).
- FIFO_DEPTH, 4, output FIFO entries (power of 2, ≥2).
- LEN_W, 16, width of the block-count field.

Ports:
- clk_i  in  1  clock, rising edge; the only clock.
- arst_n_i  in  1  reset, asynchronous, active-low.
- load_i  in  1  strobe: capture iv_i/len_i and start a run (honoured only in IDLE).
- iv_i  in  128  initial counter block, big-endian.
- len_i  in  LEN_W  number of keystream blocks; 0 = empty run.
- abort_i  in  1  strobe: terminate the current run.
- busy_o  out  1  run in progress (state ≠ IDLE).
- wrap_o  out  1  sticky: low CTR_W field wrapped during the run; cleared on accepted load.
- done_o  out  1  one-cycle pulse at normal run completion.
- core_start_o  out  1  start strobe to the core.
- core_state_o  out  128  counter block to the core (share 2 tied to zero at integration).
- core_ready_i  in  1  core ready_o.
- core_done_i  in  1  core done_o.
- core_state_i  in  128  core result share 1.
- core_state_share2_i  in  128  core result share 2.
- ks_valid_o  out  1  FIFO head valid.
- ks_ready_i  in  1  consumer accepts the head.
- ks_o  out  128  keystream share 1.
- ks_share2_o  out  128  keystream share 2.
- ks_last_o  out  1  head is the final block of the run.

## Operation
- **Reset values:** all outputs 0. State IDLE. Counter, remaining count, FIFO pointers and wrap_o cleared. FIFO data need not be cleared.
- **FSM states:**
  - IDLE: on load_i, latch ctr←iv_i and rem←len_i. If len_i=0, go to FIN; otherwise go to ISSUE.
  - ISSUE: if core_ready_i and (FIFO occupancy + in-flight) < FIFO_DEPTH, assert core_start_o for one cycle with core_state_o=ctr, then go to WAIT.
  - WAIT: on core_done_i, write {core_state_i, core_state_share2_i, last=(rem==1)} into the FIFO, then decrement rem. If rem becomes 0, go to DRAIN; otherwise go to ISSUE.
  - DRAIN: when the FIFO is empty, go to FIN.
  - FIN: pulse done_o, then go to IDLE.
- **Counter:** on each core_start_o, ctr[CTR_W-1:0] increments modulo 2^CTR_W and ctr[127:CTR_W] is unchanged. Going from all-ones to zero sets wrap_o. Generation continues after a wrap.
- **Blocks in flight:** at most one block is in flight. Slots are reserved at issue, so the FIFO never overflows and core_done_i is never dropped.
- **FIFO:** a head transfer occurs when ks_valid_o & ks_ready_i. A write and a read in the same cycle are both performed. Pointers wrap modulo FIFO_DEPTH.
- **load_i outside IDLE:** ignored.
- **abort_i in ISSUE, WAIT or DRAIN:**
  - Issuing stops.
  - An outstanding core_done_i is awaited and its result discarded.
  - The FIFO is flushed and state returns to IDLE.
  - No done_o pulse; wrap_o is kept.
- **abort_i in IDLE/FIN:** ignored.
- **abort_i and core_done_i in the same cycle:** the result is discarded.
- **Reset asserted mid-run:** returns immediately to reset values. A late core_done_i in IDLE is ignored.

## Timing
- **Load to start:** load_i at cycle 0 → core_start_o at cycle 1 at the earliest (core_ready_i high, FIFO has space).
- **Core latency:** core_done_i at cycle 13 (12-cycle core). The entry is written at the edge ending cycle 13, so ks_valid_o=1 from cycle 14.
- **Next block:** core_start_o for the next block at cycle 14 at the earliest. Sustained rate is one block per 13 cycles with no backpressure.
- **Completion:** done_o pulses the cycle after the FIFO empties following the last block; ks_last_o is high on that block.
- **Empty run:** len_i=0 gives done_o at cycle 2 with no core_start_o.
- **Abort latency:** aborting in ISSUE with nothing in flight reaches IDLE (busy_o=0) the cycle after abort_i.

## Test plan
- **Basic run:** iv=0x000…00FE, CTR_W=8, len=3, ks_ready_i=1. Required:
  - core_state_o sequence is …FE, …FF, …00.
  - wrap_o=1 after the third issue.
  - ks_last_o on block 3; done_o once.
- **Backpressure:** len=8, FIFO_DEPTH=4, ks_ready_i=0 until the FIFO is full. Required:
  - Exactly 4 core_start_o.
  - No further issue until a pop.
  - All 8 blocks delivered in order, with shares matching the core model.
- **Abort in flight:** abort_i during WAIT with 2 blocks in the FIFO. Required:
  - The pending core_done_i is swallowed.
  - ks_valid_o=0 next cycle; busy_o falls; no done_o.
- **Empty run and ignored load:** len=0 → done_o at cycle 2, no core_start_o. A load_i mid-run is ignored: iv unchanged, count unchanged.
- **Async reset:** arst_n_i low mid-WAIT. Required:
  - All outputs 0 without a clock edge.
  - A subsequent core_done_i is ignored.
  - A new load runs normally.

Source files
------------

// File: rtl/aes_ctr_keystream.sv
// rtl/aes_ctr_keystream.sv - CTR-mode keystream engine feeding a masked AES core, two-share output FIFO
module aes_ctr_keystream #(
  parameter int CTR_W      = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = 16
) (
  input  logic             clk_i,
  input  logic             arst_n_i,
  input  logic             load_i,
  input  logic [127:0]     iv_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             abort_i,
  output logic             busy_o,
  output logic             wrap_o,
  output logic             done_o,
  output logic             core_start_o,
  output logic [127:0]     core_state_o,
  input  logic             core_ready_i,
  input  logic             core_done_i,
  input  logic [127:0]     core_state_i,
  input  logic [127:0]     core_state_share2_i,
  output logic             ks_valid_o,
  input  logic             ks_ready_i,
  output logic [127:0]     ks_o,
  output logic [127:0]     ks_share2_o,
  output logic             ks_last_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  // Shift by 128 yields zero, so the mask is all ones when CTR_W is 128.
  localparam logic [127:0] LO_MASK = (128'd1 << CTR_W) - 128'd1;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN, S_FIN} state_t;

  state_t           state;
  logic [127:0]     ctr;
  logic [LEN_W-1:0] rem;
  logic             abort_pend;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [256:0]     mem [FIFO_DEPTH];

  logic [127:0] ctr_next;
  logic         ctr_wraps;
  logic         has_space;
  logic         push;
  logic         pop;
  logic         flush;
  logic [256:0] head;

  assign ctr_next  = (ctr & ~LO_MASK) | ((ctr + 128'd1) & LO_MASK);
  assign ctr_wraps = &(ctr | ~LO_MASK);
  assign has_space = count < CNT_W'(FIFO_DEPTH);

  // Only one block is ever in flight, so occupancy alone decides whether a slot is free.
  assign core_start_o = (state == S_ISSUE) && core_ready_i && !abort_i && has_space;
  assign core_state_o = ctr;
  assign busy_o       = (state != S_IDLE);

  assign push  = (state == S_WAIT) && core_done_i && !abort_i && !abort_pend;
  assign pop   = ks_valid_o && ks_ready_i;
  assign flush = abort_i && ((state == S_ISSUE) || (state == S_WAIT) || (state == S_DRAIN));

  assign ks_valid_o  = (count != '0);
  assign head        = mem[rd_ptr];
  assign ks_o        = ks_valid_o ? head[256:129] : '0;
  assign ks_share2_o = ks_valid_o ? head[128:1]   : '0;
  assign ks_last_o   = ks_valid_o & head[0];

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state      <= S_IDLE;
      ctr        <= '0;
      rem        <= '0;
      abort_pend <= 1'b0;
      wrap_o     <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (load_i) begin
            ctr        <= iv_i;
            rem        <= len_i;
            wrap_o     <= 1'b0;
            abort_pend <= 1'b0;
            state      <= (len_i == '0) ? S_FIN : S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (abort_i) begin
            state <= S_IDLE;
          end else if (core_start_o) begin
            ctr   <= ctr_next;
            state <= S_WAIT;
            if (ctr_wraps) wrap_o <= 1'b1;
          end
        end
        S_WAIT: begin
          // An aborted run still owns the core until its result comes back.
          if (abort_i || abort_pend) begin
            if (core_done_i) begin
              abort_pend <= 1'b0;
              state      <= S_IDLE;
            end else begin
              abort_pend <= 1'b1;
            end
          end else if (core_done_i) begin
            rem   <= rem - 1'b1;
            state <= (rem == LEN_W'(1)) ? S_DRAIN : S_ISSUE;
          end
        end
        S_DRAIN: begin
          if (abort_i)            state <= S_IDLE;
          else if (count == '0)   state <= S_FIN;
        end
        S_FIN: begin
          done_o <= 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= {core_state_i, core_state_share2_i, (rem == LEN_W'(1))};
  end

endmodule

// File: tb/tb_aes_ctr_keystream.sv
// tb/tb_aes_ctr_keystream.sv - directed bench for aes_ctr_keystream with a 12-cycle core model
module tb_aes_ctr_keystream;

  localparam int LEN_W = 16;
  localparam logic [127:0] K1 = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  localparam logic [127:0] K2 = 128'h5555aaaa3333cccc0f0ff0f01234fedc;
  localparam logic [127:0] IDLE_JUNK = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
  localparam logic [127:0] IV_HI = 128'h00112233445566778899aabbccddee00;

  logic             clk_i = 1'b0;
  logic             arst_n_i;
  logic             load_i;
  logic [127:0]     iv_i;
  logic [LEN_W-1:0] len_i;
  logic             abort_i;
  logic             busy_o, wrap_o, done_o, core_start_o;
  logic [127:0]     core_state_o;
  logic             core_ready_i = 1'b1;
  logic             core_done_i = 1'b0;
  logic [127:0]     core_state_i = IDLE_JUNK;
  logic [127:0]     core_state_share2_i = IDLE_JUNK;
  logic             ks_valid_o;
  logic             ks_ready_i;
  logic [127:0]     ks_o, ks_share2_o;
  logic             ks_last_o;

  aes_ctr_keystream #(.CTR_W(8), .FIFO_DEPTH(4), .LEN_W(LEN_W)) dut (
    .clk_i(clk_i), .arst_n_i(arst_n_i), .load_i(load_i), .iv_i(iv_i), .len_i(len_i),
    .abort_i(abort_i), .busy_o(busy_o), .wrap_o(wrap_o), .done_o(done_o),
    .core_start_o(core_start_o), .core_state_o(core_state_o), .core_ready_i(core_ready_i),
    .core_done_i(core_done_i), .core_state_i(core_state_i),
    .core_state_share2_i(core_state_share2_i), .ks_valid_o(ks_valid_o),
    .ks_ready_i(ks_ready_i), .ks_o(ks_o), .ks_share2_o(ks_share2_o), .ks_last_o(ks_last_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int core_cnt = 0;
  int done_cnt = 0;
  int pop_cnt = 0;
  int load_cyc = 0;
  logic [127:0] core_cap;
  logic [127:0] issue_blk[$];
  int           issue_cyc[$];
  logic [127:0] exp_blk[$];
  logic         exp_last[$];

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] sh1(input logic [127:0] b);
    return b ^ K1;
  endfunction

  function automatic logic [127:0] sh2(input logic [127:0] b);
    return {b[63:0], b[127:64]} ^ K2;
  endfunction

  // Counter block i of a run: only the low 8 bits advance.
  function automatic logic [127:0] blk(input logic [127:0] iv, input int i);
    logic [7:0] lo;
    lo = iv[7:0] + 8'(i);
    return {iv[127:8], lo};
  endfunction

  // Core model: fixed 12-cycle latency, result is a known function of the issued block.
  always @(negedge clk_i) begin
    #2;
    core_done_i         = 1'b0;
    core_state_i        = IDLE_JUNK;
    core_state_share2_i = IDLE_JUNK;
    if (core_cnt > 0) begin
      core_cnt--;
      if (core_cnt == 0) begin
        core_done_i         = 1'b1;
        core_state_i        = sh1(core_cap);
        core_state_share2_i = sh2(core_cap);
      end
    end
    if (core_start_o) begin
      core_cap = core_state_o;
      core_cnt = 12;
      issue_blk.push_back(core_state_o);
      issue_cyc.push_back(cyc);
    end
  end

  always @(negedge clk_i) begin
    #2;
    if (arst_n_i && done_o) done_cnt++;
    if (arst_n_i && ks_valid_o && ks_ready_i) begin
      pop_cnt++;
      if (exp_blk.size() == 0) begin
        check("ks_unexpected", 1'b1, 1'b0);
      end else begin
        check("ks_share1", ks_o, sh1(exp_blk[0]));
        check("ks_share2", ks_share2_o, sh2(exp_blk[0]));
        check("ks_last", ks_last_o, exp_last[0]);
        void'(exp_blk.pop_front());
        void'(exp_last.pop_front());
      end
    end
  end

  task automatic expect_run(input logic [127:0] iv, input int len);
    for (int i = 0; i < len; i++) begin
      exp_blk.push_back(blk(iv, i));
      exp_last.push_back(i == len - 1);
    end
  endtask

  task automatic start_run(input logic [127:0] iv, input int len);
    @(negedge clk_i);
    issue_blk.delete();
    issue_cyc.delete();
    iv_i     = iv;
    len_i    = LEN_W'(len);
    load_i   = 1'b1;
    load_cyc = cyc;
    @(negedge clk_i);
    load_i = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    check("done_seen", done_cnt != d0, 1'b1);
    repeat (2) @(negedge clk_i);
  endtask

  initial begin
    int d0;
    int p0;
    int n;
    logic [127:0] iv;
    arst_n_i = 1'b0; load_i = 1'b0; iv_i = '0; len_i = '0; abort_i = 1'b0; ks_ready_i = 1'b0;
    #3;
    check("rst_busy", busy_o, 1'b0);
    check("rst_ks_valid", ks_valid_o, 1'b0);
    check("rst_core_start", core_start_o, 1'b0);
    check("rst_core_state", core_state_o, '0);
    check("rst_wrap", wrap_o, 1'b0);
    repeat (2) @(negedge clk_i);
    arst_n_i = 1'b1;

    // Basic run crossing the 8-bit counter wrap.
    iv = IV_HI | 128'hfe;
    ks_ready_i = 1'b1;
    d0 = done_cnt; p0 = pop_cnt;
    expect_run(iv, 3);
    start_run(iv, 3);
    wait_done(100);
    check("basic_issues", issue_blk.size(), 3);
    check("basic_blk0", issue_blk[0], IV_HI | 128'hfe);
    check("basic_blk1", issue_blk[1], IV_HI | 128'hff);
    check("basic_blk2", issue_blk[2], IV_HI);
    check("basic_t0", issue_cyc[0], load_cyc + 1);
    check("basic_t1", issue_cyc[1], load_cyc + 14);
    check("basic_wrap", wrap_o, 1'b1);
    check("basic_done_once", done_cnt - d0, 1);
    check("basic_pops", pop_cnt - p0, 3);
    check("basic_busy", busy_o, 1'b0);

    // Backpressure: consumer stalls until the FIFO fills.
    iv = IV_HI | 128'h10;
    ks_ready_i = 1'b0;
    p0 = pop_cnt;
    expect_run(iv, 8);
    start_run(iv, 8);
    check("bp_wrap_cleared", wrap_o, 1'b0);
    repeat (80) @(negedge clk_i);
    check("bp_issues_full", issue_blk.size(), 4);
    check("bp_valid", ks_valid_o, 1'b1);
    repeat (30) @(negedge clk_i);
    check("bp_issues_hold", issue_blk.size(), 4);
    ks_ready_i = 1'b1;
    wait_done(250);
    check("bp_issues", issue_blk.size(), 8);
    check("bp_pops", pop_cnt - p0, 8);
    check("bp_blk7", issue_blk[7], IV_HI | 128'h17);

    // Abort while a block is in flight with two results queued.
    iv = IV_HI | 128'h20;
    ks_ready_i = 1'b0;
    d0 = done_cnt;
    start_run(iv, 5);
    n = 0;
    while (issue_blk.size() < 3 && n < 60) begin
      @(negedge clk_i);
      n++;
    end
    check("ab_third_issue", issue_blk.size(), 3);
    repeat (3) @(negedge clk_i);
    check("ab_valid_before", ks_valid_o, 1'b1);
    abort_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    check("ab_flushed", ks_valid_o, 1'b0);
    n = 0;
    while (busy_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    check("ab_busy_fell", busy_o, 1'b0);
    repeat (3) @(negedge clk_i);
    check("ab_valid_after", ks_valid_o, 1'b0);
    check("ab_no_done", done_cnt - d0, 0);
    check("ab_issues", issue_blk.size(), 3);

    // Empty run.
    start_run(IV_HI | 128'h33, 0);
    check("empty_busy_c1", busy_o, 1'b1);
    check("empty_done_c1", done_o, 1'b0);
    @(negedge clk_i);
    check("empty_done_c2", done_o, 1'b1);
    @(negedge clk_i);
    check("empty_done_c3", done_o, 1'b0);
    check("empty_issues", issue_blk.size(), 0);

    // A load mid-run must not disturb the counter or the count.
    iv = IV_HI | 128'h40;
    ks_ready_i = 1'b1;
    d0 = done_cnt; p0 = pop_cnt;
    expect_run(iv, 2);
    start_run(iv, 2);
    repeat (5) @(negedge clk_i);
    iv_i = 128'hffff0000ffff0000ffff0000ffff0080;
    len_i = LEN_W'(7);
    load_i = 1'b1;
    @(negedge clk_i);
    load_i = 1'b0;
    wait_done(100);
    check("ign_issues", issue_blk.size(), 2);
    check("ign_blk1", issue_blk[1], IV_HI | 128'h41);
    check("ign_pops", pop_cnt - p0, 2);
    check("ign_done_once", done_cnt - d0, 1);

    // Asynchronous reset in WAIT with one result queued.
    iv = IV_HI | 128'h50;
    ks_ready_i = 1'b0;
    start_run(iv, 3);
    n = 0;
    while (issue_blk.size() < 2 && n < 40) begin
      @(negedge clk_i);
      n++;
    end
    repeat (3) @(negedge clk_i);
    check("ar_valid_before", ks_valid_o, 1'b1);
    #1;
    arst_n_i = 1'b0;
    #1;
    check("ar_busy", busy_o, 1'b0);
    check("ar_ks_valid", ks_valid_o, 1'b0);
    check("ar_ks", ks_o, '0);
    check("ar_ks_share2", ks_share2_o, '0);
    check("ar_ks_last", ks_last_o, 1'b0);
    check("ar_core_state", core_state_o, '0);
    check("ar_core_start", core_start_o, 1'b0);
    check("ar_done", done_o, 1'b0);
    exp_blk.delete();
    exp_last.delete();
    repeat (2) @(negedge clk_i);
    arst_n_i = 1'b1;
    repeat (15) @(negedge clk_i);
    check("ar_late_busy", busy_o, 1'b0);
    check("ar_late_valid", ks_valid_o, 1'b0);
    iv = IV_HI | 128'h60;
    ks_ready_i = 1'b1;
    p0 = pop_cnt;
    expect_run(iv, 1);
    start_run(iv, 1);
    wait_done(60);
    check("ar_new_issues", issue_blk.size(), 1);
    check("ar_new_blk", issue_blk[0], IV_HI | 128'h60);
    check("ar_new_pops", pop_cnt - p0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
